gp_cmd_executor: RTL and testbench

Command-side responder for the graphics-processor request interface. It accepts one rectangle command per `en` handshake from the game controller and rasterises it into VRAM at one pixel per clock. Two operations are supported: solid fill, and blit from image ROM. It sits between the game controller's `gp_*` outputs and the VRAM write port / image ROM read port, and returns a one-cycle `finish` pulse when the command has retired.

---
 rtl/gp_cmd_executor.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_gp_cmd_executor.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gp_cmd_executor.sv
// ---------------------------------------------------------------------------
// gp_cmd_executor
//
// Rasterises one rectangle command per `en` handshake into VRAM at one pixel
// per clock. Two operations: solid fill (opcode 0) and blit from the image
// ROM (opcode 1). Returns a one-cycle `finish` pulse when the command retires,
// with `err` alongside it if the command was rejected as out of range.
//
// Parameters
//   H_RES      VRAM row stride and horizontal limit (default 640)
//   V_RES      vertical limit (default 480)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         command strobe, sampled only while idle
//   opcode     0 = fill, 1 = blit
//   tl_x/tl_y  top-left corner, inclusive
//   br_x/br_y  bottom-right corner, inclusive
//   arg        fill colour (RGB444) or ROM base index (byte address arg<<6)
//   rom_data   ROM pixel, valid the cycle after rom_addr
//   vram_we    VRAM write enable
//   vram_addr  VRAM address y*H_RES + x
//   vram_data  pixel to write
//   rom_addr   image ROM read address
//   finish     one-cycle retire pulse
//   busy       high from accept through the finish cycle
//   err        one-cycle pulse with finish for a rejected command
//
// Build option
//   GP_TRANSPARENT_KEY_EN  when defined, blit pixels equal to 12'hF0F are
//                          skipped (no write); timing is unchanged.
// ---------------------------------------------------------------------------
module gp_cmd_executor #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        opcode,
    input  logic [9:0]  tl_x,
    input  logic [8:0]  tl_y,
    input  logic [9:0]  br_x,
    input  logic [8:0]  br_y,
    input  logic [11:0] arg,
    input  logic [11:0] rom_data,
    output logic        vram_we,
    output logic [18:0] vram_addr,
    output logic [11:0] vram_data,
    output logic [17:0] rom_addr,
    output logic        finish,
    output logic        busy,
    output logic        err
);

    localparam logic [10:0] H_LIM  = 11'(H_RES);
    localparam logic [9:0]  V_LIM  = 10'(V_RES);
    localparam logic [31:0] H_BITS = 32'(H_RES);
    localparam logic [18:0] H_STEP = 19'(H_RES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_BLIT,
        S_BLIT_DRAIN,
        S_DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [9:0]  tl_x_reg, tl_x_next;
    logic [9:0]  br_x_reg, br_x_next;
    logic [8:0]  br_y_reg, br_y_next;
    logic [11:0] arg_reg, arg_next;
    logic [9:0]  x_reg, x_next;
    logic [8:0]  y_reg, y_next;
    logic [18:0] row_base_reg, row_base_next;
    logic [18:0] dest_reg, dest_next;       // blit: destination of the pixel currently on rom_addr
    logic [18:0] addr_reg, addr_next;
    logic [11:0] data_reg, data_next;
    logic [17:0] rom_addr_reg, rom_addr_next;
    logic        we_reg, we_next;
    logic        src_rom_reg, src_rom_next; // current write takes its data from rom_data
    logic        finish_reg, finish_next;
    logic        busy_reg, busy_next;
    logic        err_reg, err_next;

    // ------------------------------------------------------------------
    // Starting row base tl_y*H_RES as a constant shift-add: one shifted
    // copy of tl_y per set bit of H_RES, summed below.
    // ------------------------------------------------------------------
    logic [18:0] base_term [19];
    logic [18:0] start_base;

    generate
        for (genvar gi = 0; gi < 19; gi++) begin : g_base_term
            assign base_term[gi] = H_BITS[gi] ? (19'(tl_y) << gi) : 19'd0;
        end
    endgenerate

    always_comb begin
        start_base = '0;
        for (int i = 0; i < 19; i++) begin
            start_base = start_base + base_term[i];
        end
    end

    logic [18:0] start_addr;
    logic [18:0] next_row_start;
    logic        out_of_range;
    logic        empty_rect;
    logic        row_end;
    logic        last_px;

    assign start_addr     = start_base + {9'd0, tl_x};
    assign next_row_start = row_base_reg + H_STEP + {9'd0, tl_x_reg};
    assign out_of_range   = ({1'b0, br_x} >= H_LIM) || ({1'b0, br_y} >= V_LIM);
    assign empty_rect     = (tl_x > br_x) || (tl_y > br_y);
    assign row_end        = (x_reg == br_x_reg);
    assign last_px        = row_end && (y_reg == br_y_reg);

    // ------------------------------------------------------------------
    // Output stage. In blit the data comes straight from the ROM in the
    // write cycle; the held value is refreshed every cycle so vram_data
    // keeps its last written value once writes stop.
    // ------------------------------------------------------------------
    logic key_hit;

`ifdef GP_TRANSPARENT_KEY_EN
    logic [18:0] held_addr_reg;

    assign key_hit   = src_rom_reg && (rom_data == 12'hF0F);
    // A keyed pixel is not written, so the visible address stays put.
    assign vram_addr = key_hit ? held_addr_reg : addr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_addr_reg <= '0;
        end else begin
            held_addr_reg <= vram_addr;
        end
    end
`else
    assign key_hit   = 1'b0;
    assign vram_addr = addr_reg;
`endif

    assign vram_we   = we_reg && !key_hit;
    assign vram_data = (src_rom_reg && !key_hit) ? rom_data : data_reg;
    assign rom_addr  = rom_addr_reg;
    assign finish    = finish_reg;
    assign busy      = busy_reg;
    assign err       = err_reg;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            tl_x_reg     <= '0;
            br_x_reg     <= '0;
            br_y_reg     <= '0;
            arg_reg      <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            row_base_reg <= '0;
            dest_reg     <= '0;
            addr_reg     <= '0;
            data_reg     <= '0;
            rom_addr_reg <= '0;
            we_reg       <= 1'b0;
            src_rom_reg  <= 1'b0;
            finish_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tl_x_reg     <= tl_x_next;
            br_x_reg     <= br_x_next;
            br_y_reg     <= br_y_next;
            arg_reg      <= arg_next;
            x_reg        <= x_next;
            y_reg        <= y_next;
            row_base_reg <= row_base_next;
            dest_reg     <= dest_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
            rom_addr_reg <= rom_addr_next;
            we_reg       <= we_next;
            src_rom_reg  <= src_rom_next;
            finish_reg   <= finish_next;
            busy_reg     <= busy_next;
            err_reg      <= err_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        tl_x_next     = tl_x_reg;
        br_x_next     = br_x_reg;
        br_y_next     = br_y_reg;
        arg_next      = arg_reg;
        x_next        = x_reg;
        y_next        = y_reg;
        row_base_next = row_base_reg;
        dest_next     = dest_reg;
        addr_next     = addr_reg;
        data_next     = vram_data;
        rom_addr_next = rom_addr_reg;
        we_next       = 1'b0;
        src_rom_next  = 1'b0;
        finish_next   = 1'b0;
        busy_next     = busy_reg;
        err_next      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                busy_next = 1'b0;
                if (en) begin
                    tl_x_next     = tl_x;
                    br_x_next     = br_x;
                    br_y_next     = br_y;
                    arg_next      = arg;
                    x_next        = tl_x;
                    y_next        = tl_y;
                    row_base_next = start_base;
                    busy_next     = 1'b1;
                    if (out_of_range) begin
                        state_next  = S_DONE;
                        finish_next = 1'b1;
                        err_next    = 1'b1;
                    end else if (empty_rect) begin
                        state_next  = S_DONE;
                        finish_next = 1'b1;
                    end else if (!opcode) begin
                        // First fill pixel is presented in the cycle after accept.
                        state_next = S_FILL;
                        we_next    = 1'b1;
                        addr_next  = start_addr;
                        data_next  = arg;
                    end else begin
                        state_next    = S_BLIT;
                        rom_addr_next = {arg, 6'b0};
                        dest_next     = start_addr;
                    end
                end
            end

            S_FILL: begin
                if (last_px) begin
                    state_next  = S_DONE;
                    finish_next = 1'b1;
                end else begin
                    we_next   = 1'b1;
                    data_next = arg_reg;
                    if (row_end) begin
                        x_next        = tl_x_reg;
                        y_next        = y_reg + 9'd1;
                        row_base_next = row_base_reg + H_STEP;
                        addr_next     = next_row_start;
                    end else begin
                        x_next    = x_reg + 10'd1;
                        addr_next = addr_reg + 19'd1;
                    end
                end
            end

            S_BLIT: begin
                // The pixel fetched this cycle is written next cycle at dest_reg.
                we_next      = 1'b1;
                src_rom_next = 1'b1;
                addr_next    = dest_reg;
                if (last_px) begin
                    state_next = S_BLIT_DRAIN;
                end else begin
                    rom_addr_next = rom_addr_reg + 18'd1;
                    if (row_end) begin
                        x_next        = tl_x_reg;
                        y_next        = y_reg + 9'd1;
                        row_base_next = row_base_reg + H_STEP;
                        dest_next     = next_row_start;
                    end else begin
                        x_next    = x_reg + 10'd1;
                        dest_next = dest_reg + 19'd1;
                    end
                end
            end

            S_BLIT_DRAIN: begin
                state_next  = S_DONE;
                finish_next = 1'b1;
            end

            S_DONE: begin
                state_next = S_IDLE;
                busy_next  = 1'b0;
            end

            default: begin
                state_next = S_IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_gp_cmd_executor.sv
// ---------------------------------------------------------------------------
// tb_gp_cmd_executor
//
// Self-checking bench for gp_cmd_executor. A table of rectangle commands is
// applied one by one; a reference model pushes the expected VRAM writes to a
// queue which a negedge scoreboard pops whenever vram_we is seen. Each command
// also checks finish latency, err, busy, write count and blit ROM addresses.
// Hand-written sequences cover reset, reset mid-fill and en held while busy.
// ---------------------------------------------------------------------------
module tb_gp_cmd_executor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        opcode = 1'b0;
    logic [9:0]  tl_x = '0;
    logic [8:0]  tl_y = '0;
    logic [9:0]  br_x = '0;
    logic [8:0]  br_y = '0;
    logic [11:0] arg = '0;
    logic [11:0] rom_data = '0;
    logic        vram_we;
    logic [18:0] vram_addr;
    logic [11:0] vram_data;
    logic [17:0] rom_addr;
    logic        finish;
    logic        busy;
    logic        err;

    int total = 0;
    int bad = 0;
    int rom_mode = 0;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];

    typedef struct {
        bit op;
        int tlx;
        int tly;
        int brx;
        int bry;
        int arg;
        int rom_mode;
        int exp_writes;
        int exp_finish;
        bit exp_err;
    } vec_t;

    gp_cmd_executor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .opcode    (opcode),
        .tl_x      (tl_x),
        .tl_y      (tl_y),
        .br_x      (br_x),
        .br_y      (br_y),
        .arg       (arg),
        .rom_data  (rom_data),
        .vram_we   (vram_we),
        .vram_addr (vram_addr),
        .vram_data (vram_data),
        .rom_addr  (rom_addr),
        .finish    (finish),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Image ROM: mode 0 returns addr & 0xFFF; mode 1 returns a keyed
    // pattern for the three words starting at byte address 0x400.
    function automatic logic [11:0] rom_fn(input logic [17:0] a, input int mode);
        logic [17:0] off;
        off = a - 18'h400;
        if (mode == 1 && off == 18'd0) return 12'h123;
        if (mode == 1 && off == 18'd1) return 12'hF0F;
        if (mode == 1 && off == 18'd2) return 12'h456;
        return a[11:0];
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr, rom_mode);

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Scoreboard: every observed VRAM write must match the head of the queue.
    always @(negedge clk) begin
        if (vram_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got write at addr %0d want no write", vram_addr);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(vram_addr), 64'(e.addr));
                check("wr_data", 64'(vram_data), 64'(e.data));
            end
        end
    end

    // Reference model: push the writes a command should produce.
    task automatic push_model(input vec_t v, output int npix);
        logic [17:0] b;
        logic [11:0] d;
        int i;
        npix = 0;
        if (v.brx >= 640 || v.bry >= 480 || v.tlx > v.brx || v.tly > v.bry) return;
        b = 18'(v.arg) << 6;
        i = 0;
        for (int y = v.tly; y <= v.bry; y++) begin
            for (int x = v.tlx; x <= v.brx; x++) begin
                if (!v.op) begin
                    exp_q.push_back('{y * 640 + x, v.arg});
                end else begin
                    d = rom_fn(b + 18'(i), v.rom_mode);
`ifdef GP_TRANSPARENT_KEY_EN
                    if (d != 12'hF0F) exp_q.push_back('{y * 640 + x, int'(d)});
`else
                    exp_q.push_back('{y * 640 + x, int'(d)});
`endif
                end
                i++;
            end
        end
        npix = i;
    endtask

    task automatic drive_cmd(input vec_t v);
        opcode   = v.op;
        tl_x     = 10'(v.tlx);
        tl_y     = 9'(v.tly);
        br_x     = 10'(v.brx);
        br_y     = 9'(v.bry);
        arg      = 12'(v.arg);
        rom_mode = v.rom_mode;
        en       = 1'b1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int npix, first_we, fin_c, nw, busy_bad, err_bad;
        logic err_seen;
        logic [17:0] b;
        first_we = -1; fin_c = -1; nw = 0; busy_bad = 0; err_bad = 0; err_seen = 1'b0;
        b = 18'(v.arg) << 6;
        @(negedge clk);
        drive_cmd(v);
        @(posedge clk);              // accept edge k
        #1 en = 1'b0;
        push_model(v, npix);
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (v.op && c <= npix) check("rom_addr", 64'(rom_addr), 64'(b + 18'(c - 1)));
            if (busy !== 1'b1) busy_bad++;
            if (vram_we === 1'b1) begin
                nw++;
                if (first_we < 0) first_we = c;
            end
            if (finish === 1'b1) begin
                fin_c = c;
                err_seen = err;
                break;
            end else if (err !== 1'b0) begin
                err_bad++;
            end
        end
        if (fin_c < 0) begin
            total++;
            bad++;
            $display("FAIL finish_timeout: got no finish want finish at cycle %0d (vec %0d)", v.exp_finish, idx);
        end
        check("finish_cycle", 64'(fin_c), 64'(v.exp_finish));
        check("err_pulse", 64'(err_seen), 64'(v.exp_err));
        check("write_count", 64'(nw), 64'(v.exp_writes));
        check("busy_high", 64'(busy_bad), 64'd0);
        check("err_early", 64'(err_bad), 64'd0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        if (v.exp_writes > 0) check("first_write", 64'(first_we), v.op ? 64'd2 : 64'd1);
        @(negedge clk);
        check("busy_after", 64'(busy), 64'd0);
        check("finish_after", 64'(finish), 64'd0);
        $display("vec %0d op=%0d (%0d,%0d)-(%0d,%0d) arg=%03h finish@%0d writes=%0d err=%0d",
                 idx, v.op, v.tlx, v.tly, v.brx, v.bry, v.arg, fin_c, nw, err_seen);
        exp_q.delete();
    endtask

    vec_t vecs[11];
    int   key_writes;

    initial begin
`ifdef GP_TRANSPARENT_KEY_EN
        key_writes = 2;
`else
        key_writes = 3;
`endif
        //           op  tlx  tly  brx  bry  arg     mode writes fin err
        vecs[0]  = '{0,    0,   0,   1,   1, 'hABC, 0, 4,          5, 0};
        vecs[1]  = '{1,   10,   5,  12,   5, 'h002, 0, 3,          5, 0};
        vecs[2]  = '{0,    5,   0,   4,   0, 'h000, 0, 0,          1, 0};
        vecs[3]  = '{0,    5,   0, 640,   0, 'h000, 0, 0,          1, 1};
        vecs[4]  = '{0,  638, 478, 639, 479, 'h5A5, 0, 4,          5, 0};
        vecs[5]  = '{1,  100, 200, 101, 202, 'hFFF, 0, 6,          8, 0};
        vecs[6]  = '{1,    0,   0,  10, 480, 'h001, 0, 0,          1, 1};
        vecs[7]  = '{0,    0,   9,   0,   3, 'h777, 0, 0,          1, 0};
        vecs[8]  = '{0,  639, 479, 639, 479, 'h123, 0, 1,          2, 0};
        vecs[9]  = '{1,    0,   0,   2,   0, 'h010, 1, key_writes, 5, 0};
        vecs[10] = '{1,    0,   0,   0,   0, 'h003, 0, 1,          3, 0};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs", 64'({vram_we, vram_addr, vram_data, rom_addr, finish, busy, err}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Reset during pixel 3 of a 4x4 fill
        begin
            vec_t r;
            r = '{0, 0, 0, 3, 3, 'h111, 0, 16, 17, 0};
            @(negedge clk);
            drive_cmd(r);
            @(posedge clk);
            #1 en = 1'b0;
            exp_q.push_back('{0, 'h111});
            exp_q.push_back('{1, 'h111});
            exp_q.push_back('{2, 'h111});
            repeat (3) @(negedge clk);
            #2 rst_n = 1'b0;
            #1 check("midop_reset_outputs", 64'({vram_we, vram_addr, vram_data, rom_addr, finish, busy, err}), 64'd0);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                check("midop_no_write", 64'(vram_we), 64'd0);
            end
            rst_n = 1'b1;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                check("post_reset_idle", 64'({vram_we, busy, finish}), 64'd0);
            end
            check("midop_queue", 64'(exp_q.size()), 64'd0);
            $display("reset mid-fill: outputs cleared, writes stopped");
            run_vec(100, vecs[0]);
        end

        // en held high across a busy fill: exactly one extra command
        begin
            vec_t h;
            int fins[$];
            int nw, busy_bad;
            logic exp_busy;
            h = '{0, 0, 0, 1, 0, 'h7E7, 0, 2, 3, 0};
            nw = 0; busy_bad = 0;
            @(negedge clk);
            drive_cmd(h);
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                exp_q.push_back('{0, 'h7E7});
                exp_q.push_back('{1, 'h7E7});
            end
            for (int c = 1; c <= 14; c++) begin
                @(negedge clk);
                exp_busy = (c <= 3) || (c >= 5 && c <= 7);
                if (busy !== exp_busy) busy_bad++;
                if (vram_we === 1'b1) nw++;
                if (finish === 1'b1) fins.push_back(c);
                if (c == 5) en = 1'b0;
            end
            check("held_finish_count", 64'(fins.size()), 64'd2);
            if (fins.size() >= 2) begin
                check("held_finish1", 64'(fins[0]), 64'd3);
                check("held_finish2", 64'(fins[1]), 64'd7);
            end
            check("held_writes", 64'(nw), 64'd4);
            check("held_busy", 64'(busy_bad), 64'd0);
            check("held_queue", 64'(exp_q.size()), 64'd0);
            $display("en held: finishes=%0d writes=%0d", fins.size(), nw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
